// File: rtl/regfile_sb.sv
// Register file with per-register busy scoreboard, optional write-to-read
// forwarding and a registered count of pending registers.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              w_en,
    input  logic [AW-1:0]     w_addr,
    input  logic [XLEN-1:0]   w_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic [AW:0]       busy_cnt
);

    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic            wr_ok;
    logic            iss_ok;

    assign wr_ok  = w_en && (w_addr != '0);
    assign iss_ok = iss_en && (iss_addr != '0);

    // A same-cycle issue overrides the write-back clear.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[w_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[w_addr] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;

        assign ra  = rd_addr[g*AW +: AW];
        assign fwd = (BYPASS != 0) && wr_ok && (w_addr == ra);

        assign rd_data[g*XLEN +: XLEN] =
            (rst || ra == '0) ? '0 :
            fwd               ? w_data :
                                mem_q[ra];

        assign rd_busy[g] = !rst && busy_q[ra] && !fwd;
    end

    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: two instances (forwarding on/off) with three read ports,
// checked against an array-based reference model.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 3;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic            w_en = 1'b0;
    logic [AW-1:0]   w_addr = '0;
    logic [XLEN-1:0] w_data = '0;
    logic            iss_en = 1'b0;
    logic [AW-1:0]   iss_addr = '0;

    logic [NRD*XLEN-1:0] rd1, rd0;
    logic [NRD-1:0]      bz1, bz0;
    logic [AW:0]         cnt1, cnt0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd1),
        .rd_busy(bz1), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(cnt1)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd0),
        .rd_busy(bz0), .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(cnt0)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic [NRD*XLEN-1:0] d1;
        logic [NRD*XLEN-1:0] d0;
        logic [NRD-1:0]  b1;
        logic [NRD-1:0]  b0;
        logic [AW:0]     cnt;
    } exp_t;

    exp_t q[$];

    logic [XLEN-1:0] m_mem [NREG];
    bit              m_busy [NREG];

    int total = 0;
    int bad   = 0;

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int popcnt();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_mem[i]  = '0;
            m_busy[i] = 0;
        end
    endtask

    task automatic step(string tag, bit we, int wa, logic [31:0] wd,
                        bit ie, int ia, int a0, int a1, int a2);
        exp_t e;
        int   ad[NRD];
        @(posedge clk);
        #1;
        ad[0] = a0; ad[1] = a1; ad[2] = a2;
        w_en = we; w_addr = AW'(wa); w_data = wd;
        iss_en = ie; iss_addr = AW'(ia);
        for (int i = 0; i < NRD; i++) rd_addr[i*AW +: AW] = AW'(ad[i]);
        e.tag = tag;
        e.cnt = (AW+1)'(popcnt());
        for (int i = 0; i < NRD; i++) begin
            bit hit;
            hit = we && wa != 0 && wa == ad[i];
            e.d0[i*XLEN +: XLEN] = (ad[i] == 0) ? 32'h0 : m_mem[ad[i]];
            e.d1[i*XLEN +: XLEN] = (ad[i] == 0) ? 32'h0 :
                                   hit ? wd : m_mem[ad[i]];
            e.b0[i] = (ad[i] != 0) && m_busy[ad[i]];
            e.b1[i] = (ad[i] != 0) && m_busy[ad[i]] && !hit;
        end
        q.push_back(e);
        if (we && wa != 0) begin
            m_mem[wa]  = wd;
            m_busy[wa] = 0;
        end
        if (ie && ia != 0) m_busy[ia] = 1;
    endtask

    task automatic do_reset(string tag, int a0, int a1, int a2);
        exp_t e;
        @(posedge clk);
        #1;
        w_en = 0; iss_en = 0;
        rd_addr[0 +: AW] = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
        rd_addr[2*AW +: AW] = AW'(a2);
        rst = 1;
        model_clear();
        e.tag = tag;
        e.d1 = '0; e.d0 = '0; e.b1 = '0; e.b0 = '0; e.cnt = '0;
        q.push_back(e);
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk({e.tag, ".rd_byp"}, 128'(rd1), 128'(e.d1));
                chk({e.tag, ".rd_nob"}, 128'(rd0), 128'(e.d0));
                chk({e.tag, ".busy_byp"}, 128'(bz1), 128'(e.b1));
                chk({e.tag, ".busy_nob"}, 128'(bz0), 128'(e.b0));
                chk({e.tag, ".cnt_byp"}, 128'(cnt1), 128'(e.cnt));
                chk({e.tag, ".cnt_nob"}, 128'(cnt0), 128'(e.cnt));
            end
        end
    end

    initial begin
        model_clear();
        do_reset("por", 1, 5, 31);

        step("wr5", 1, 5, 32'hDEADBEEF, 0, 0, 5, 5, 0);
        step("rd5", 0, 0, 32'h0, 0, 0, 5, 5, 5);

        step("x0w", 1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0);
        step("x0r", 0, 0, 32'h0, 0, 0, 0, 0, 0);

        step("iss3", 0, 0, 32'h0, 1, 3, 7, 3, 9);
        step("iss7", 0, 0, 32'h0, 1, 7, 7, 3, 9);
        step("iss9", 0, 0, 32'h0, 1, 9, 7, 3, 9);
        step("sb3", 0, 0, 32'h0, 0, 0, 7, 3, 9);
        step("wb7", 1, 7, 32'h777, 0, 0, 7, 3, 9);
        step("sb2", 0, 0, 32'h0, 0, 0, 7, 3, 9);

        step("iss4", 0, 0, 32'h0, 1, 4, 4, 0, 0);
        step("b4", 0, 0, 32'h0, 0, 0, 4, 4, 4);
        step("sim4", 1, 4, 32'h12, 1, 4, 4, 4, 4);
        step("post4", 0, 0, 32'h0, 0, 0, 4, 4, 4);
        step("reiss4", 0, 0, 32'h0, 1, 4, 4, 0, 0);
        step("cnt4", 0, 0, 32'h0, 0, 0, 4, 0, 0);

        step("w6", 1, 6, 32'h55, 0, 0, 6, 6, 6);
        step("r6", 0, 0, 32'h0, 0, 0, 6, 6, 6);

        step("w1", 1, 1, 32'h11, 0, 0, 1, 0, 0);
        step("w2", 1, 2, 32'h22, 1, 5, 2, 0, 0);
        step("w3", 1, 3, 32'h33, 1, 8, 1, 2, 3);
        step("pend", 0, 0, 32'h0, 0, 0, 1, 2, 3);
        do_reset("rstmid", 1, 2, 3);
        step("after", 0, 0, 32'h0, 0, 0, 1, 2, 3);

        for (int n = 0; n < 400; n++) begin
            int wa, ia, a0;
            wa = int'($urandom_range(0, 9));
            ia = int'($urandom_range(0, 9));
            a0 = ($urandom_range(0, 1) != 0) ? wa : int'($urandom_range(0, 31));
            if ($urandom_range(0, 79) == 0) begin
                do_reset("rnd_rst", a0, ia, wa);
            end else begin
                step("rnd", bit'($urandom_range(0, 1)), wa, $urandom,
                     bit'($urandom_range(0, 1)), ia, a0,
                     int'($urandom_range(0, 9)), ia);
            end
        end

        repeat (3) @(negedge clk);
        chk("drain", 128'(q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: data width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, power of two, at least 2; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 enables write-to-read forwarding, 0 disables it.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port rd_addr, input, NRD*AW bits: read addresses; port i occupies bits [i*AW +: AW].
REQ-008 SHALL have port rd_data, output, NRD*XLEN bits: read data; port i occupies bits [i*XLEN +: XLEN].
REQ-009 SHALL have port rd_busy, output, NRD bits: 1 when the addressed register has an outstanding pending write.
REQ-010 SHALL have port w_en, input, 1 bit: write-back strobe.
REQ-011 SHALL have port w_addr, input, AW bits: write-back address.
REQ-012 SHALL have port w_data, input, XLEN bits: write-back data.
REQ-013 SHALL have port iss_en, input, 1 bit: issue strobe; marks iss_addr pending.
REQ-014 SHALL have port iss_addr, input, AW bits: destination register of the issued instruction.
REQ-015 SHALL have port busy_cnt, output, AW+1 bits: registered count of pending registers.

Function
REQ-016 SHALL hardwire register 0: reads return 0, writes are ignored, it is never marked busy.
REQ-017 SHALL perform reads combinationally with zero-cycle latency; all NRD ports are independent and may share an address.
REQ-018 SHALL, when w_en=1 and w_addr!=0, write w_data to mem[w_addr] at the clock edge.
REQ-019 SHALL, when BYPASS=1, return w_data on port i in the same cycle when w_en=1, w_addr==rd_addr[i] and rd_addr[i]!=0.
REQ-020 SHALL, when BYPASS=0, return the stored value until the edge after the write.
REQ-021 SHALL keep one busy bit per register: iss_en with iss_addr!=0 sets it, and w_en with w_addr!=0 clears it.
REQ-022 SHALL, on iss_en and w_en in the same cycle to the same nonzero address, leave the busy bit set (the new issue wins), while the data write still occurs.
REQ-023 SHALL leave the busy bit set when iss_en targets a register that is already busy (no nesting or counting).
REQ-024 SHALL leave the busy bit at 0 and write the data when w_en targets a register that is not busy.
REQ-025 SHALL drive rd_busy[i] = busy[rd_addr[i]], except when BYPASS=1 and a same-cycle w_en to that address forwards the data, in which case rd_busy[i]=0.
REQ-026 SHALL update busy_cnt at each edge to the population count of the next-state busy bits; its range is 0..NREG-1.
REQ-027 SHALL not act on out-of-range addresses; none are possible because NREG is a power of two.

Reset
REQ-028 SHALL, while rst=1, immediately clear all registers to 0, all busy bits to 0 and busy_cnt to 0, independent of clk.
REQ-029 SHALL, while rst=1, drive rd_data to all zeros and rd_busy to all zeros, and ignore w_en and iss_en.
REQ-030 SHALL accept a reset asserted mid-operation (pending writes outstanding): all pending state is discarded and the first edge after rst deasserts behaves as from power-up.

Verification
REQ-031 SHALL be verified by a write-then-read scenario: reset, then w_en with w_addr=5 and w_data=0xDEADBEEF; the same cycle reads 0xDEADBEEF with BYPASS=1 and 0 with BYPASS=0, and the next cycle reads 0xDEADBEEF in both modes.
REQ-032 SHALL be verified by an x0 scenario: w_en with w_addr=0 and w_data=0xFFFFFFFF, plus iss_en with iss_addr=0; rd_data=0, rd_busy=0 and busy_cnt=0.
REQ-033 SHALL be verified by a scoreboard scenario: issue 3, 7 and 9 on consecutive cycles gives busy_cnt=3 and rd_busy=1 for r7; write-back of r7 gives busy_cnt=2 and rd_busy(r7)=0.
REQ-034 SHALL be verified by a simultaneous-event scenario: with r4 busy, iss_en and w_en both target r4 with w_data=0x12; after the edge r4=0x12, busy(r4)=1 and busy_cnt is unchanged.
REQ-035 SHALL be verified by a reset mid-operation scenario: r1..r3 written and 2 pending, then rst pulses between edges; all reads return 0 and busy_cnt=0 immediately.
REQ-036 SHALL be verified by a multi-port scenario with NRD=3: all three ports read r6=0x55 at once and all three return 0x55.
